// File: rtl/hangman_pkg.sv
// Shared types and sizing helpers for the hangman round engine.
package hangman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_e;

    localparam int CHAR_W_DEF     = 5;
    localparam int MAX_LEN_DEF    = 16;
    localparam int MAX_MISSES_DEF = 9;
    localparam int TIME_LIMIT_DEF = 30;
    localparam int SCORE_W_DEF    = 4;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hangman_engine_if.sv
// Front-end <-> engine bundle: setter/guesser controls in, masks, counters and events out.
interface hangman_engine_if import hangman_pkg::*; #(
    parameter int CHAR_W     = CHAR_W_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF,
    parameter int MAX_MISSES = MAX_MISSES_DEF,
    parameter int TIME_LIMIT = TIME_LIMIT_DEF,
    parameter int SCORE_W    = SCORE_W_DEF
) ();
    localparam int LEN_W  = cnt_w(MAX_LEN);
    localparam int MISS_W = cnt_w(MAX_MISSES);
    localparam int TIME_W = cnt_w(TIME_LIMIT);

    logic               new_round;
    logic [CHAR_W-1:0]  char_in;
    logic               ld;
    logic               word_done;
    logic [CHAR_W-1:0]  guess_in;
    logic               guess_valid;
    logic               guess_ready;
    logic               sec_tick;
    logic [LEN_W-1:0]   word_len;
    logic [MAX_LEN-1:0] reveal_mask;
    logic [MAX_LEN-1:0] hit_mask;
    logic [LEN_W-1:0]   remaining;
    logic [MISS_W-1:0]  miss_count;
    logic [TIME_W-1:0]  time_left;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               repeat_pulse;
    logic               round_over;
    logic               timed_out;
    logic [SCORE_W-1:0] p1score;
    logic [SCORE_W-1:0] p2score;
    logic [2:0]         state;

    modport master (
        output new_round, char_in, ld, word_done, guess_in, guess_valid, sec_tick,
        input  guess_ready, word_len, reveal_mask, hit_mask, remaining, miss_count,
               time_left, hit_pulse, miss_pulse, repeat_pulse, round_over, timed_out,
               p1score, p2score, state
    );

    modport slave (
        input  new_round, char_in, ld, word_done, guess_in, guess_valid, sec_tick,
        output guess_ready, word_len, reveal_mask, hit_mask, remaining, miss_count,
               time_left, hit_pulse, miss_pulse, repeat_pulse, round_over, timed_out,
               p1score, p2score, state
    );

endinterface

// File: rtl/hangman_engine_match_unit.sv
// Match unit: compares the latched guess against every stored position at once and
// returns the not-yet-revealed matches plus their count.
module hangman_engine_match_unit import hangman_pkg::*; #(
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = cnt_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0][CHAR_W-1:0] word_i,
    input  logic [LEN_W-1:0]               len_i,
    input  logic [CHAR_W-1:0]              guess_i,
    input  logic [MAX_LEN-1:0]             reveal_i,
    output logic [MAX_LEN-1:0]             hits_o,
    output logic [LEN_W-1:0]               hit_cnt_o
);

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_lane
        // Positions beyond the loaded length hold stale characters and must never match.
        assign hits_o[i] = (LEN_W'(i) < len_i) && (word_i[i] == guess_i) && !reveal_i[i];
    end

    always_comb begin
        hit_cnt_o = '0;
        for (int k = 0; k < MAX_LEN; k++) hit_cnt_o = hit_cnt_o + LEN_W'(hits_o[k]);
    end

endmodule

// File: rtl/hangman_engine.sv
// Round-level hangman engine: word storage, guess checking, miss/timer tracking and scores.
module hangman_engine import hangman_pkg::*; #(
    parameter int CHAR_W     = CHAR_W_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF,
    parameter int MAX_MISSES = MAX_MISSES_DEF,
    parameter int TIME_LIMIT = TIME_LIMIT_DEF,
    parameter int SCORE_W    = SCORE_W_DEF
) (
    input  logic           clk_i,
    input  logic           resetn_i,
    hangman_engine_if.slave hm
);
    localparam int LEN_W  = cnt_w(MAX_LEN);
    localparam int MISS_W = cnt_w(MAX_MISSES);
    localparam int TIME_W = cnt_w(TIME_LIMIT);
    localparam int NSYM   = 1 << CHAR_W;
    localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

    state_e                        state_q, state_d;
    logic [MAX_LEN-1:0][CHAR_W-1:0] word_q, word_d;
    logic [LEN_W-1:0]              len_q, len_d, rem_q, rem_d;
    logic [MAX_LEN-1:0]            reveal_q, reveal_d, hitm_q, hitm_d;
    logic [MISS_W-1:0]             miss_q, miss_d;
    logic [TIME_W-1:0]             time_q, time_d;
    logic [NSYM-1:0]               used_q, used_d;
    logic [CHAR_W-1:0]             guess_q, guess_d;
    logic                          hitp_q, hitp_d, missp_q, missp_d, repp_q, repp_d;
    logic                          tout_q, tout_d;
    logic [SCORE_W-1:0]            p1_q, p1_d, p2_q, p2_d;

    logic [MAX_LEN-1:0] hits;
    logic [LEN_W-1:0]   hit_cnt, rem_after;
    logic [MISS_W-1:0]  miss_after;
    logic               accept, is_repeat, timeout;

    hangman_engine_match_unit #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
        .word_i   (word_q),
        .len_i    (len_q),
        .guess_i  (guess_q),
        .reveal_i (reveal_q),
        .hits_o   (hits),
        .hit_cnt_o(hit_cnt)
    );

    assign accept     = (state_q == PLAY) && hm.guess_valid;
    assign timeout    = (state_q == PLAY) && !hm.guess_valid && hm.sec_tick && (time_q == TIME_W'(1));
    assign is_repeat  = used_q[guess_q];
    assign rem_after  = rem_q - hit_cnt;
    assign miss_after = miss_q + 1'b1;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hm.new_round) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                // len_d already includes an ld sampled on the same edge.
                LOAD:  if (hm.word_done && len_d != '0) state_d = PLAY;
                PLAY:  if (accept) state_d = CHECK;
                       else if (timeout) state_d = LOSE;
                CHECK: if (is_repeat) state_d = PLAY;
                       else if (hit_cnt != '0) state_d = (rem_after == '0) ? WIN : PLAY;
                       else state_d = (miss_after == MISS_W'(MAX_MISSES)) ? LOSE : PLAY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        word_d   = word_q;   len_d    = len_q;    rem_d  = rem_q;
        reveal_d = reveal_q; hitm_d   = hitm_q;   miss_d = miss_q;
        time_d   = time_q;   used_d   = used_q;   guess_d = guess_q;
        tout_d   = tout_q;   p1_d     = p1_q;     p2_d   = p2_q;
        hitp_d   = 1'b0;     missp_d  = 1'b0;     repp_d = 1'b0;
        if (hm.new_round) begin
            len_d = '0; reveal_d = '0; hitm_d = '0; miss_d = '0; used_d = '0; tout_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (hm.ld && len_q != LEN_W'(MAX_LEN)) begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (LEN_W'(i) == len_q) word_d[i] = hm.char_in;
                        len_d = len_q + 1'b1;
                    end
                    if (hm.word_done && len_d != '0) begin
                        time_d = TIME_W'(TIME_LIMIT);
                        rem_d  = len_d;
                    end
                end
                PLAY: begin
                    if (accept) begin
                        guess_d = hm.guess_in;
                    end else if (hm.sec_tick) begin
                        time_d = time_q - 1'b1;
                        if (timeout) begin
                            tout_d = 1'b1;
                            p1_d   = (p1_q == SMAX) ? p1_q : p1_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (is_repeat) begin
                        repp_d = 1'b1;
                    end else begin
                        used_d[guess_q] = 1'b1;
                        if (hit_cnt != '0) begin
                            reveal_d = reveal_q | hits;
                            hitm_d   = hits;
                            rem_d    = rem_after;
                            hitp_d   = 1'b1;
                            if (rem_after == '0) p2_d = (p2_q == SMAX) ? p2_q : p2_q + 1'b1;
                        end else begin
                            miss_d  = miss_after;
                            hitm_d  = '0;
                            missp_d = 1'b1;
                            if (miss_after == MISS_W'(MAX_MISSES))
                                p1_d = (p1_q == SMAX) ? p1_q : p1_q + 1'b1;
                        end
                    end
                    if (state_d == PLAY) time_d = TIME_W'(TIME_LIMIT);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            word_q <= '0; len_q <= '0; rem_q <= '0; reveal_q <= '0; hitm_q <= '0;
            miss_q <= '0; time_q <= '0; used_q <= '0; guess_q <= '0;
            hitp_q <= 1'b0; missp_q <= 1'b0; repp_q <= 1'b0; tout_q <= 1'b0;
            p1_q <= '0; p2_q <= '0;
        end else begin
            word_q <= word_d; len_q <= len_d; rem_q <= rem_d; reveal_q <= reveal_d;
            hitm_q <= hitm_d; miss_q <= miss_d; time_q <= time_d; used_q <= used_d;
            guess_q <= guess_d; hitp_q <= hitp_d; missp_q <= missp_d; repp_q <= repp_d;
            tout_q <= tout_d; p1_q <= p1_d; p2_q <= p2_d;
        end
    end

    always_comb begin
        hm.guess_ready  = (state_q == PLAY);
        hm.round_over   = (state_q == WIN) || (state_q == LOSE);
        hm.state        = state_q;
        hm.word_len     = len_q;
        hm.reveal_mask  = reveal_q;
        hm.hit_mask     = hitm_q;
        hm.remaining    = rem_q;
        hm.miss_count   = miss_q;
        hm.time_left    = time_q;
        hm.hit_pulse    = hitp_q;
        hm.miss_pulse   = missp_q;
        hm.repeat_pulse = repp_q;
        hm.timed_out    = tout_q;
        hm.p1score      = p1_q;
        hm.p2score      = p2_q;
    end

endmodule

// File: doc/hangman_engine.md
# hangman_engine

Round-level game engine for the two-player hangman design. Stores the setter's word of up to MAX_LEN characters, checks guesses in parallel against every stored position, and tracks revealed positions, misses, the per-guess time limit and both players' scores. It sits between the keyboard/switch front end and the VGA drawing logic, which consumes its masks and event pulses.

## Interface
Parameters:
- CHAR_W, 5, bits per character code
- MAX_LEN, 16, maximum word length (≥1)
- MAX_MISSES, 9, misses that complete the gallows (one drawn part each)
- TIME_LIMIT, 30, seconds allowed per guess (≥1)
- SCORE_W, 4, score counter width

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- new_round  in  1  pulse: discard current round, enter LOAD
- char_in  in  CHAR_W  setter character
- ld  in  1  pulse: append char_in to word
- word_done  in  1  pulse: finish loading, start play
- guess_in  in  CHAR_W  guessed character
- guess_valid  in  1  guess offered
- guess_ready  out  1  engine accepts guess this cycle
- sec_tick  in  1  one-cycle pulse per second
- word_len  out  clog2(MAX_LEN+1)  stored length
- reveal_mask  out  MAX_LEN  bit i set = position i revealed
- hit_mask  out  MAX_LEN  positions newly revealed by last guess
- remaining  out  clog2(MAX_LEN+1)  unrevealed positions
- miss_count  out  clog2(MAX_MISSES+1)  parts drawn so far
- time_left  out  clog2(TIME_LIMIT+1)  seconds left for current guess
- hit_pulse, miss_pulse, repeat_pulse  out  1  one-cycle guess outcomes
- round_over  out  1  high in WIN or LOSE
- timed_out  out  1  LOSE reached by timer
- p1score, p2score  out  SCORE_W  setter / guesser scores
- state  out  3  current state encoding

All outputs reset to 0; state resets to IDLE.

## Operation
- States: IDLE, LOAD, PLAY, CHECK, WIN, LOSE.
- new_round in any state: word_len, reveal_mask, hit_mask, miss_count, used-letter set, timed_out cleared; → LOAD. Scores kept (cleared only by resetn). new_round has priority over all other inputs.
- LOAD: ld writes char_in to position word_len, word_len+1. ld with word_len==MAX_LEN ignored. word_done with word_len==0 ignored; otherwise → PLAY, time_left=TIME_LIMIT, remaining=word_len.
- PLAY: guess_ready=1 only here. Accept on guess_valid&&guess_ready: latch guess, → CHECK.
- CHECK (one cycle): compare guess with positions < word_len.
  - Letter already in used set (2^CHAR_W bits): repeat_pulse, no other change.
  - Else mark used; hits = matches & ~reveal_mask. hits≠0: reveal_mask|=hits, hit_mask=hits, remaining-=popcount(hits), hit_pulse. hits==0: miss_count+1, hit_mask=0, miss_pulse.
  - Next: remaining==0 → WIN (p2score+1); miss_count==MAX_MISSES → LOSE (p1score+1); else PLAY with time_left=TIME_LIMIT.
- Timer: in PLAY, sec_tick decrements time_left; sec_tick with time_left==1 → LOSE, timed_out=1, p1score+1. Accepted guess in the same cycle wins over the timeout tick. Timer frozen outside PLAY.
- WIN/LOSE hold all outputs until new_round; guesses and ld ignored.
- Scores saturate at 2^SCORE_W−1.

## Timing
- Guess accepted at edge N → CHECK during cycle N..N+1; masks, counters, pulses and next state updated at edge N+1; pulses high for exactly one cycle after N+1. Next guess acceptable at edge N+2 earliest.
- ld/word_done effective on the edge where sampled; new_round takes one edge.
- Reset mid-round: everything returns to IDLE/zero immediately (asynchronous), released synchronously.

## Structure
- hangman_pkg: state enum, CHAR_W/MAX_LEN defaults, clog2-based width localparams.
- Sub-module match_unit: combinational parallel compare of guess against word array, gated by word_len, plus popcount of hits.
- Word stored in flops (MAX_LEN×CHAR_W), not RAM, to allow single-cycle compare.

## Test plan
- Load "ABA" (codes 1,2,1), guess 1 → hit_mask=3'b101, remaining=1; guess 2 → WIN, p2score=1, round_over=1.
- Load "AB", guess 9 codes absent → miss_count=9, LOSE, p1score=1, timed_out=0.
- Guess 1 twice on "AB" → second gives repeat_pulse, miss_count and masks unchanged.
- PLAY with TIME_LIMIT=3, three sec_ticks, no guess → LOSE, timed_out=1, p1score+1; guess with tick at time_left=1 → guess processed, no timeout.
- LOAD 17 ld pulses at MAX_LEN=16 → word_len=16; word_done at len 0 → stays LOAD.
- resetn low during CHECK → state IDLE, all outputs 0; scores saturate at 15 after 16 wins.
